// File: rtl/load_ext_pipe.sv
// Load extract/extend pipeline stage.
// Picks the byte/half/word/dword field at a byte offset inside an aligned
// load word, sign- or zero-extends it, and flags misaligned accesses.
// The result sits in a 2-entry skid buffer: an output register plus a
// spill register.
//
// Handshake: a request is accepted on a rising edge where i_Valid=1 and
// o_Ready=1. A result is transferred on a rising edge where o_Valid=1 and
// i_Ready=1. o_Valid never depends on i_Ready. o_Ready comes straight from
// a flop ("spill register empty"), so it has no combinational path from
// i_Ready. i_Flush overrides every accept and transfer in its cycle.
module load_ext_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [DATA_WIDTH-1:0] i_Data,
    input  logic [OFF_W-1:0]      i_Offset,
    input  logic [1:0]            i_Size,
    input  logic                  i_Signed,
    input  logic                  i_Flush,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Misalign
);

    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] msb_mask;
    logic [DATA_WIDTH-1:0] new_data;
    logic                  new_mis;
    logic                  sign_bit;
    int                    field_bits;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_mis;
    logic                  spill_valid;
    logic [DATA_WIDTH-1:0] spill_data;
    logic                  spill_mis;

    logic accept;
    logic xfer;

    assign accept = i_Valid & ~spill_valid;
    assign xfer   = out_valid & i_Ready;

    // Field extraction: shift the addressed byte to bit 0, keep field_bits
    // bits, fill the rest with the field MSB or with zeros.
    always_comb begin
        field_bits = 8;
        new_mis    = 1'b0;
        shifted    = i_Data >> {i_Offset, 3'b000};
        case (i_Size)
            2'b00: field_bits = 8;
            2'b01: begin
                field_bits = 16;
                new_mis    = i_Offset[0];
            end
            2'b10: begin
                field_bits = 32;
                new_mis    = (i_Offset[1:0] != 2'b00);
            end
            default: begin
                field_bits = DATA_WIDTH;
                new_mis    = (DATA_WIDTH == 32) || (i_Offset != '0);
            end
        endcase
        mask     = ONES >> (DATA_WIDTH - field_bits);
        msb_mask = mask & ~(mask >> 1);
        sign_bit = i_Signed & ((shifted & msb_mask) != '0);
        if (new_mis) begin
            new_data = '0;
        end else begin
            new_data = (shifted & mask) | (sign_bit ? ~mask : '0);
        end
    end

    // Skid buffer: output register refills from spill first, then from the
    // incoming result; a stalled output register pushes new results to spill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_mis     <= 1'b0;
            spill_valid <= 1'b0;
            spill_data  <= '0;
            spill_mis   <= 1'b0;
        end else if (i_Flush) begin
            out_valid   <= 1'b0;
            spill_valid <= 1'b0;
        end else if (!out_valid || xfer) begin
            if (spill_valid) begin
                // spill full implies o_Ready=0, so no accept this cycle
                out_valid   <= 1'b1;
                out_data    <= spill_data;
                out_mis     <= spill_mis;
                spill_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= new_data;
                out_mis   <= new_mis;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            spill_valid <= 1'b1;
            spill_data  <= new_data;
            spill_mis   <= new_mis;
        end
    end

    assign o_Ready    = ~spill_valid;
    assign o_Valid    = out_valid;
    assign o_Data     = out_data;
    assign o_Misalign = out_mis;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Bench for load_ext_pipe: a 32-bit instance driven through a scoreboard
// plus a 64-bit instance checked with directed vectors.
module tb_load_ext_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 32-bit instance signals
    logic        i_Valid, o_Ready, i_Flush, o_Valid, i_Ready, o_Misalign, i_Signed;
    logic [31:0] i_Data, o_Data;
    logic [1:0]  i_Offset, i_Size;

    // 64-bit instance signals
    logic        v64, rdy64, fl64, ov64, ir64, mis64, sg64;
    logic [63:0] d64, od64;
    logic [2:0]  off64;
    logic [1:0]  sz64;

    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic rand_ready = 1'b0;

    load_ext_pipe #(.DATA_WIDTH(32), .OFF_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_Data(i_Data), .i_Offset(i_Offset), .i_Size(i_Size), .i_Signed(i_Signed),
        .i_Flush(i_Flush), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Data(o_Data),
        .o_Misalign(o_Misalign)
    );

    load_ext_pipe #(.DATA_WIDTH(64), .OFF_W(3)) dut64 (
        .clk(clk), .rst_n(rst_n), .i_Valid(v64), .o_Ready(rdy64),
        .i_Data(d64), .i_Offset(off64), .i_Size(sz64), .i_Signed(sg64),
        .i_Flush(fl64), .o_Valid(ov64), .i_Ready(ir64), .o_Data(od64),
        .o_Misalign(mis64)
    );

    // ---------------- reference model (32-bit) ----------------
    function automatic logic [32:0] model(logic [31:0] d, logic [1:0] off,
                                          logic [1:0] sz, logic sg);
        logic [31:0] s;
        logic [31:0] r;
        logic        mis;
        s   = d >> (8 * int'(off));
        r   = 32'h0;
        mis = 1'b0;
        case (sz)
            2'b00: r = sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            2'b01: if (off[0]) mis = 1'b1;
                   else r = sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            2'b10: if (off != 2'd0) mis = 1'b1;
                   else r = d;
            default: mis = 1'b1;
        endcase
        return {mis, mis ? 32'h0 : r};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on output transfer, push on accept, clear on flush/reset.
    always @(negedge clk) begin
        if (!rst_n || i_Flush) begin
            exp_q.delete();
        end else begin
            if (o_Valid && i_Ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_output", 64'(exp_q.size()), 64'd1);
                else
                    check("out_result", 64'({o_Misalign, o_Data}), 64'(exp_q.pop_front()));
            end
            if (i_Valid && o_Ready)
                exp_q.push_back(model(i_Data, i_Offset, i_Size, i_Signed));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_Valid  = 1'b0;
        i_Data   = $urandom;
        i_Offset = 2'($urandom_range(0, 3));
        i_Size   = 2'($urandom_range(0, 3));
        i_Signed = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] off,
                        input logic [1:0] sz, input logic sg);
        int  n;
        logic ok;
        i_Valid  = 1'b1;
        i_Data   = d;
        i_Offset = off;
        i_Size   = sz;
        i_Signed = sg;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            if (rand_ready) i_Ready = 1'($urandom_range(0, 1));
            ok = o_Ready;
            step();
            n++;
        end
        if (!ok) check("send_timeout", 64'(n), 64'd0);
    endtask

    task automatic drain();
        int n;
        i_Ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [32:0] ea, eb, ee;
        rst_n = 1'b1;
        i_Ready = 1'b1;
        i_Flush = 1'b0;
        idle();
        v64 = 1'b0; fl64 = 1'b0; ir64 = 1'b1; d64 = '0; off64 = '0; sz64 = '0; sg64 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_o_valid", 64'(o_Valid), 64'd0);
        check("rst_o_ready", 64'(o_Ready), 64'd1);
        check("rst_o_data", 64'(o_Data), 64'd0);
        check("rst_o_misalign", 64'(o_Misalign), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // sign-extended byte, latency 1
        send(32'h12AB80FF, 2'd1, 2'b00, 1'b1);
        idle();
        check("byte_s_valid", 64'(o_Valid), 64'd1);
        check("byte_s_data", 64'(o_Data), 64'hFFFFFF80);
        check("byte_s_mis", 64'(o_Misalign), 64'd0);

        // zero / sign extended half
        send(32'h80017FFF, 2'd2, 2'b01, 1'b0);
        idle();
        check("half_u_data", 64'(o_Data), 64'h00008001);
        send(32'h80017FFF, 2'd2, 2'b01, 1'b1);
        idle();
        check("half_s_data", 64'(o_Data), 64'hFFFF8001);

        // misalignment
        send(32'hDEADBEEF, 2'd3, 2'b01, 1'b1);
        idle();
        check("half_mis_flag", 64'(o_Misalign), 64'd1);
        check("half_mis_data", 64'(o_Data), 64'd0);
        send(32'hCAFEF00D, 2'd0, 2'b11, 1'b0);
        idle();
        check("dword32_valid", 64'(o_Valid), 64'd1);
        check("dword32_mis", 64'(o_Misalign), 64'd1);
        step();

        // random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        rand_ready = 1'b0;
        drain();

        // backpressure: A,B accepted, C held
        ea = model(32'h000000A1, 2'd0, 2'b00, 1'b0);
        eb = model(32'h0000B200, 2'd1, 2'b00, 1'b0);
        i_Ready = 1'b0;
        send(32'h000000A1, 2'd0, 2'b00, 1'b0);
        send(32'h0000B200, 2'd1, 2'b00, 1'b0);
        i_Data = 32'h00C30000; i_Offset = 2'd2; i_Size = 2'b00; i_Signed = 1'b0;
        step();
        check("bp_ready_low", 64'(o_Ready), 64'd0);
        check("bp_out_a", 64'(o_Data), 64'(ea[31:0]));
        step();
        check("bp_ready_still_low", 64'(o_Ready), 64'd0);
        i_Ready = 1'b1;
        step();
        check("bp_ready_back", 64'(o_Ready), 64'd1);
        check("bp_out_b", 64'(o_Data), 64'(eb[31:0]));
        send(32'h00C30000, 2'd2, 2'b00, 1'b0);
        idle();
        drain();

        // flush: output full + simultaneous accept
        i_Ready = 1'b0;
        send(32'h11111111, 2'd0, 2'b10, 1'b0);
        i_Valid = 1'b1; i_Data = 32'h22222222; i_Offset = 2'd0; i_Size = 2'b10;
        i_Flush = 1'b1;
        step();
        i_Flush = 1'b0;
        idle();
        check("flush1_valid", 64'(o_Valid), 64'd0);
        check("flush1_ready", 64'(o_Ready), 64'd1);
        i_Ready = 1'b1;
        repeat (3) step();
        check("flush1_no_stale", 64'(o_Valid), 64'd0);

        // flush: both entries full, request held
        i_Ready = 1'b0;
        send(32'h33333333, 2'd0, 2'b10, 1'b0);
        send(32'h44444444, 2'd0, 2'b10, 1'b0);
        i_Data = 32'h55555555; i_Flush = 1'b1;
        step();
        i_Flush = 1'b0;
        idle();
        check("flush2_valid", 64'(o_Valid), 64'd0);
        check("flush2_ready", 64'(o_Ready), 64'd1);
        i_Ready = 1'b1;
        repeat (3) step();
        check("flush2_no_stale", 64'(o_Valid), 64'd0);

        // reset mid-operation; no accept while reset is low
        i_Ready = 1'b0;
        send(32'h66666666, 2'd0, 2'b10, 1'b0);
        send(32'h77777777, 2'd0, 2'b10, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(o_Valid), 64'd0);
        check("midrst_ready", 64'(o_Ready), 64'd1);
        check("midrst_data", 64'(o_Data), 64'd0);
        check("midrst_mis", 64'(o_Misalign), 64'd0);
        i_Valid = 1'b1; i_Data = 32'h88888888; i_Size = 2'b10; i_Offset = 2'd0;
        step();
        rst_n = 1'b1;
        idle();
        step();
        check("rst_no_accept", 64'(o_Valid), 64'd0);
        i_Ready = 1'b1;
        ee = model(32'h0000F0E1, 2'd0, 2'b01, 1'b1);
        send(32'h0000F0E1, 2'd0, 2'b01, 1'b1);
        idle();
        check("post_rst_first", 64'({o_Valid, o_Data}), 64'({1'b1, ee[31:0]}));
        drain();

        // 64-bit instance
        d64 = 64'h8000_0000_0000_0000; off64 = 3'd4; sz64 = 2'b10; sg64 = 1'b1; v64 = 1'b1;
        step();
        v64 = 1'b0;
        check("w64_valid", 64'(ov64), 64'd1);
        check("w64_data", od64, 64'hFFFF_FFFF_8000_0000);
        check("w64_mis", 64'(mis64), 64'd0);
        d64 = 64'h8123_4567_89AB_CDEF; off64 = 3'd0; sz64 = 2'b11; sg64 = 1'b0; v64 = 1'b1;
        step();
        v64 = 1'b0;
        check("dw64_data", od64, 64'h8123_4567_89AB_CDEF);
        off64 = 3'd4; v64 = 1'b1;
        step();
        v64 = 1'b0;
        check("dw64_mis", 64'({mis64, od64 != 64'd0}), 64'({1'b1, 1'b0}));
        d64 = 64'hBEEF_0000_0000_0000; off64 = 3'd6; sz64 = 2'b01; sg64 = 1'b1; v64 = 1'b1;
        step();
        v64 = 1'b0;
        check("h64_data", od64, 64'hFFFF_FFFF_FFFF_BEEF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
